// File: rtl/reg_query_sched.sv
// reg_query_sched: round-robin scheduler that serves one registry value query at a time
// (size lookup, buffer allocation, then a streamed data read).
module reg_query_sched #(
   parameter int NREQ  = 4,
   parameter int KEYW  = 16,
   parameter int DATAW = 32,
   parameter int MAXB  = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*KEYW-1:0]     req_key,
   output logic [NREQ-1:0]          req_ready,
   output logic                     st_cmd_valid,
   output logic                     st_cmd_size_only,
   output logic [KEYW-1:0]          st_cmd_key,
   input  logic                     st_cmd_ready,
   input  logic                     st_rsp_valid,
   input  logic [DATAW-1:0]         st_rsp_data,
   input  logic                     st_rsp_err,
   output logic                     st_rsp_ready,
   output logic                     alloc_req,
   output logic [15:0]              alloc_words,
   input  logic                     alloc_gnt,
   output logic                     out_valid,
   output logic [$clog2(NREQ)-1:0]  out_id,
   output logic [DATAW-1:0]         out_data,
   output logic                     out_last,
   output logic                     out_err,
   input  logic                     out_ready
);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {IDLE, SZ_CMD, SZ_WAIT, ALLOC, RD_CMD, RD_STREAM, FIN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d, id_q, id_d, win, idx;
   logic [KEYW-1:0] key_q, key_d;
   logic [15:0]     words_q, words_d, cnt_q, cnt_d;
   logic            err_q, err_d, found;
   logic [31:0]     size, wcalc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IW'(NREQ-1);
         id_q    <= '0;
         key_q   <= '0;
         words_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         key_q   <= key_d;
         words_q <= words_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // size in bytes rounded up to whole DATAW-bit words
   assign size  = 32'(st_rsp_data[15:0]);
   assign wcalc = (size * 32'd8 + 32'(DATAW - 1)) / 32'(DATAW);

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      id_d             = id_q;
      key_d            = key_q;
      words_d          = words_q;
      cnt_d            = cnt_q;
      err_d            = err_q;
      req_ready        = '0;
      st_cmd_valid     = 1'b0;
      st_cmd_size_only = 1'b0;
      st_cmd_key       = key_q;
      st_rsp_ready     = 1'b0;
      alloc_req        = 1'b0;
      alloc_words      = '0;
      out_valid        = 1'b0;
      out_id           = id_q;
      out_data         = '0;
      out_last         = 1'b0;
      out_err          = 1'b0;
      found            = 1'b0;
      win              = '0;
      idx              = '0;
      // search starts one past the last granted requester
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(ptr_q) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      case (state_q)
         IDLE: if (found) begin
            req_ready = NREQ'(1) << win;
            ptr_d     = win;
            id_d      = win;
            key_d     = req_key[win*KEYW +: KEYW];
            words_d   = '0;
            cnt_d     = '0;
            err_d     = 1'b0;
            state_d   = SZ_CMD;
         end
         SZ_CMD: begin
            st_cmd_valid     = 1'b1;
            st_cmd_size_only = 1'b1;
            if (st_cmd_ready) state_d = SZ_WAIT;
         end
         SZ_WAIT: begin
            st_rsp_ready = 1'b1;
            if (st_rsp_valid) begin
               if (st_rsp_err || size > 32'(MAXB)) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end else if (size == 32'd0) begin
                  state_d = FIN;
               end else begin
                  words_d = wcalc[15:0];
                  state_d = ALLOC;
               end
            end
         end
         ALLOC: begin
            alloc_req   = 1'b1;
            alloc_words = words_q;
            if (alloc_gnt) state_d = RD_CMD;
         end
         RD_CMD: begin
            st_cmd_valid = 1'b1;
            if (st_cmd_ready) state_d = RD_STREAM;
         end
         RD_STREAM: begin
            st_rsp_ready = out_ready;
            out_valid    = st_rsp_valid;
            out_data     = st_rsp_data;
            out_err      = st_rsp_err;
            out_last     = st_rsp_err || (cnt_q == words_q - 16'd1);
            if (st_rsp_valid && out_ready) begin
               if (out_last) state_d = IDLE;
               else cnt_d = cnt_q + 16'd1;
            end
         end
         FIN: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_err   = err_q;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_reg_query_sched.sv
// tb_reg_query_sched: directed checks of grant order, size/alloc/read flow, error paths,
// backpressure and mid-query reset.
module tb_reg_query_sched;
   logic        clk = 1'b0, rst;
   logic [3:0]  req_valid;
   logic [63:0] req_key;
   logic [3:0]  req_ready;
   logic        st_cmd_valid, st_cmd_size_only, st_cmd_ready;
   logic [15:0] st_cmd_key;
   logic        st_rsp_valid, st_rsp_err, st_rsp_ready;
   logic [31:0] st_rsp_data;
   logic        alloc_req, alloc_gnt;
   logic [15:0] alloc_words;
   logic        out_valid, out_last, out_err, out_ready;
   logic [1:0]  out_id;
   logic [31:0] out_data;
   int total = 0, bad = 0;

   reg_query_sched dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
      .st_cmd_valid(st_cmd_valid), .st_cmd_size_only(st_cmd_size_only), .st_cmd_key(st_cmd_key),
      .st_cmd_ready(st_cmd_ready), .st_rsp_valid(st_rsp_valid), .st_rsp_data(st_rsp_data),
      .st_rsp_err(st_rsp_err), .st_rsp_ready(st_rsp_ready), .alloc_req(alloc_req),
      .alloc_words(alloc_words), .alloc_gnt(alloc_gnt), .out_valid(out_valid), .out_id(out_id),
      .out_data(out_data), .out_last(out_last), .out_err(out_err), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [15:0] key_of(input int i);
      return (i == 0) ? 16'h0042 : 16'(16'h0010 + i);
   endfunction

   task automatic zero_chk(input string tag);
      #1;
      chk({tag, "_a"}, {req_ready, st_cmd_valid, st_cmd_size_only, st_cmd_key, st_rsp_ready,
                        alloc_req, alloc_words}, 64'd0);
      chk({tag, "_b"}, {out_valid, out_id, out_data, out_last, out_err}, 64'd0);
   endtask

   task automatic grant(input logic [3:0] rv, input int exp);
      req_valid = rv;
      #1 chk("grant", req_ready, 64'(1 << exp));
      cyc();
   endtask

   task automatic size_phase(input int id, input logic [15:0] size, input logic serr);
      #1;
      chk("busy_rdy", req_ready, 0);
      chk("sz_cmd", st_cmd_valid, 1);
      chk("sz_only", st_cmd_size_only, 1);
      chk("sz_key", st_cmd_key, key_of(id));
      chk("sz_id", out_id, id);
      st_cmd_ready = 1;
      cyc();
      st_cmd_ready = 0;
      st_rsp_valid = 1;
      st_rsp_data  = {16'hFFFF, size};
      st_rsp_err   = serr;
      #1 chk("sz_rdy", st_rsp_ready, 1);
      chk("sz_noalloc", alloc_req, 0);
      cyc();
      st_rsp_valid = 0;
      st_rsp_err   = 0;
      st_rsp_data  = 0;
   endtask

   task automatic fin_phase(input int id, input logic err);
      #1;
      chk("fin_valid", out_valid, 1);
      chk("fin_last", out_last, 1);
      chk("fin_data", out_data, 0);
      chk("fin_err", out_err, err);
      chk("fin_id", out_id, id);
      chk("fin_noalloc", alloc_req, 0);
      chk("fin_nocmd", st_cmd_valid, 0);
      out_ready = 1;
      cyc();
      out_ready = 0;
   endtask

   task automatic alloc_rd(input int words, input int gd);
      #1;
      chk("alloc_req", alloc_req, 1);
      chk("alloc_words", alloc_words, words);
      repeat (gd) begin
         cyc();
         #1 chk("alloc_hold", {alloc_req, alloc_words}, {1'b1, 16'(words)});
      end
      alloc_gnt = 1;
      cyc();
      alloc_gnt = 0;
      #1 chk("rd_cmd", st_cmd_valid, 1);
      chk("rd_only", st_cmd_size_only, 0);
      st_cmd_ready = 1;
      cyc();
      st_cmd_ready = 0;
   endtask

   task automatic stream(input int words, input int id);
      out_ready = 1;
      for (int b = 1; b <= words; b++) begin
         st_rsp_valid = 1;
         st_rsp_data  = 32'hD000_0000 + 32'(b);
         #1;
         chk("s_valid", out_valid, 1);
         chk("s_data", out_data, 32'hD000_0000 + 32'(b));
         chk("s_last", out_last, b == words);
         chk("s_id", out_id, id);
         chk("s_err", out_err, 0);
         chk("s_rdy", st_rsp_ready, 1);
         cyc();
      end
      st_rsp_valid = 0;
      out_ready    = 0;
      #1 chk("s_done", out_valid, 0);
   endtask

   task automatic do_reset();
      rst = 1;
      cyc();
      cyc();
      rst = 0;
      zero_chk("reset");
   endtask

   initial begin
      req_valid = 0; req_key = {16'h0013, 16'h0012, 16'h0011, 16'h0042};
      st_cmd_ready = 0; st_rsp_valid = 0; st_rsp_err = 0; st_rsp_data = 0;
      alloc_gnt = 0; out_ready = 0;
      do_reset();
      // normal query: size 10 -> 3 words, grant after 3 cycles
      grant(4'b0001, 0);
      req_valid = 0;
      size_phase(0, 16'd10, 0);
      alloc_rd(3, 3);
      stream(3, 0);
      // round robin with all requesters asserted; empty values keep it short
      do_reset();
      for (int i = 0; i < 5; i++) begin
         grant(4'b1111, i % 4);
         size_phase(i % 4, 16'd0, 0);
         fin_phase(i % 4, 0);
      end
      req_valid = 0;
      // store lookup error
      grant(4'b0100, 2);
      req_valid = 0;
      size_phase(2, 16'd5, 1);
      fin_phase(2, 1);
      // size limits
      grant(4'b1000, 3);
      req_valid = 0;
      size_phase(3, 16'd257, 0);
      fin_phase(3, 1);
      grant(4'b0001, 0);
      req_valid = 0;
      size_phase(0, 16'd256, 0);
      alloc_rd(64, 0);
      stream(64, 0);
      // backpressure: out_ready 1,0,0,1 over a 2-word read
      grant(4'b0010, 1);
      req_valid = 0;
      size_phase(1, 16'd8, 0);
      alloc_rd(2, 1);
      out_ready = 1; st_rsp_valid = 1; st_rsp_data = 32'hB0B0_0001;
      #1 chk("bp_d1", out_data, 32'hB0B0_0001);
      chk("bp_r1", st_rsp_ready, 1);
      cyc();
      out_ready = 0; st_rsp_data = 32'hB0B0_0002;
      for (int s = 0; s < 2; s++) begin
         #1 chk("bp_stall_rdy", st_rsp_ready, 0);
         chk("bp_stall", {out_valid, out_last, out_data}, {1'b1, 1'b1, 32'hB0B0_0002});
         cyc();
      end
      out_ready = 1;
      #1 chk("bp_r4", st_rsp_ready, 1);
      chk("bp_d2", out_data, 32'hB0B0_0002);
      cyc();
      st_rsp_valid = 0; out_ready = 0;
      #1 chk("bp_done", out_valid, 0);
      // reset in the middle of a read
      grant(4'b0001, 0);
      req_valid = 0;
      size_phase(0, 16'd12, 0);
      alloc_rd(3, 0);
      out_ready = 1; st_rsp_valid = 1; st_rsp_data = 32'hC000_0001;
      #1 chk("mid_beat", {out_valid, out_last}, 2'b10);
      cyc();
      st_rsp_valid = 0; out_ready = 0; st_rsp_data = 0;
      rst = 1;
      cyc();
      rst = 0;
      zero_chk("mid_rst");
      grant(4'b0010, 1);
      req_valid = 0;
      size_phase(1, 16'd0, 0);
      fin_phase(1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
